// File: rtl/reaction_timer.sv
// Reaction-game timer: takes a random delay, lights the LED after it, then measures
// the player's reaction in milliseconds, flagging false starts and timeouts.
module reaction_timer #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int MAX_MS      = 9999
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        button,
    input  logic [13:0] random,
    input  logic        rnd_ready,
    output logic        led,
    output logic        busy,
    output logic [13:0] result_ms,
    output logic        result_valid,
    output logic        false_start,
    output logic        timeout
);

    localparam int TICK_DIV = CLK_FREQ_HZ / 1000;
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [13:0]   MAX_V     = 14'(MAX_MS);
    localparam logic [13:0]   MAX_M1    = 14'(MAX_MS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_RND,
        S_DELAY,
        S_REACT
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] prescaler_q, prescaler_d;
    logic [13:0]   delay_cnt_q, delay_cnt_d;
    logic [13:0]   rt_cnt_q, rt_cnt_d;
    logic [13:0]   result_ms_q, result_ms_d;
    logic          led_q, led_d;
    logic          busy_q, busy_d;
    logic          result_valid_q, result_valid_d;
    logic          false_start_q, false_start_d;
    logic          timeout_q, timeout_d;
    logic          tick;

    assign tick = (prescaler_q == TICK_LAST);

    always_comb begin
        state_d        = state_q;
        delay_cnt_d    = delay_cnt_q;
        rt_cnt_d       = rt_cnt_q;
        result_ms_d    = result_ms_q;
        led_d          = led_q;
        busy_d         = busy_q;
        result_valid_d = 1'b0;
        false_start_d  = false_start_q;
        timeout_d      = timeout_q;
        // The prescaler only runs while a millisecond count is in progress.
        if ((state_q == S_DELAY) || (state_q == S_REACT)) begin
            prescaler_d = tick ? '0 : prescaler_q + 1'b1;
        end else begin
            prescaler_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d       = S_WAIT_RND;
                    busy_d        = 1'b1;
                    false_start_d = 1'b0;
                    timeout_d     = 1'b0;
                end
            end
            S_WAIT_RND: begin
                if (rnd_ready) begin
                    delay_cnt_d = (random == 14'd0) ? 14'd1 : random;
                    prescaler_d = '0;
                    state_d     = S_DELAY;
                end
            end
            S_DELAY: begin
                if (button) begin
                    state_d        = S_IDLE;
                    busy_d         = 1'b0;
                    false_start_d  = 1'b1;
                    result_ms_d    = 14'd0;
                    result_valid_d = 1'b1;
                end else if (tick) begin
                    if (delay_cnt_q == 14'd1) begin
                        state_d     = S_REACT;
                        led_d       = 1'b1;
                        rt_cnt_d    = 14'd0;
                        prescaler_d = '0;
                    end else begin
                        delay_cnt_d = delay_cnt_q - 14'd1;
                    end
                end
            end
            S_REACT: begin
                // A press in a tick cycle reports the count from before that tick.
                if (button) begin
                    state_d        = S_IDLE;
                    busy_d         = 1'b0;
                    led_d          = 1'b0;
                    result_ms_d    = rt_cnt_q;
                    result_valid_d = 1'b1;
                end else if (tick) begin
                    if (rt_cnt_q == MAX_M1) begin
                        state_d        = S_IDLE;
                        busy_d         = 1'b0;
                        led_d          = 1'b0;
                        result_ms_d    = MAX_V;
                        timeout_d      = 1'b1;
                        result_valid_d = 1'b1;
                    end else begin
                        rt_cnt_d = rt_cnt_q + 14'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            prescaler_q    <= '0;
            delay_cnt_q    <= 14'd0;
            rt_cnt_q       <= 14'd0;
            result_ms_q    <= 14'd0;
            led_q          <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            false_start_q  <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            prescaler_q    <= prescaler_d;
            delay_cnt_q    <= delay_cnt_d;
            rt_cnt_q       <= rt_cnt_d;
            result_ms_q    <= result_ms_d;
            led_q          <= led_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
            false_start_q  <= false_start_d;
            timeout_q      <= timeout_d;
        end
    end

    assign led          = led_q;
    assign busy         = busy_q;
    assign result_ms    = result_ms_q;
    assign result_valid = result_valid_q;
    assign false_start  = false_start_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_reaction_timer.sv
// Bench for reaction_timer: elapsed-time game model checked every cycle, plus
// directed rounds with hand-computed latencies and results.
module tb_reaction_timer;

    localparam int CLK_HZ = 10_000;
    localparam int MAXMS  = 50;
    localparam int TD     = CLK_HZ / 1000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        button = 1'b0;
    logic [13:0] random = 14'd0;
    logic        rnd_ready = 1'b0;
    logic        led, busy, result_valid, false_start, timeout;
    logic [13:0] result_ms;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: phase 0 idle, 1 waiting for random, 2 delay, 3 react; el = cycles in phase.
    int   m_phase = 0;
    int   m_el = 0;
    int   m_d = 0;
    logic m_led = 0, m_busy = 0, m_rv = 0, m_fs = 0, m_to = 0;
    int   m_res = 0;
    logic prev_rv = 0;

    reaction_timer #(.CLK_FREQ_HZ(CLK_HZ), .MAX_MS(MAXMS)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .button(button),
        .random(random), .rnd_ready(rnd_ready), .led(led), .busy(busy),
        .result_ms(result_ms), .result_valid(result_valid),
        .false_start(false_start), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        m_rv = 1'b0;
        if (!reset_n) begin
            m_phase = 0; m_el = 0; m_led = 0; m_busy = 0; m_fs = 0; m_to = 0; m_res = 0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_phase = 1; m_busy = 1; m_fs = 0; m_to = 0;
                end
                1: if (rnd_ready) begin
                    m_d = (random == 0) ? 1 : int'(random);
                    m_phase = 2; m_el = 0;
                end
                2: if (button) begin
                    m_phase = 0; m_busy = 0; m_fs = 1; m_res = 0; m_rv = 1;
                end else begin
                    m_el++;
                    if (m_el == m_d * TD) begin
                        m_phase = 3; m_led = 1; m_el = 0;
                    end
                end
                default: if (button) begin
                    m_res = m_el / TD;
                    m_phase = 0; m_busy = 0; m_led = 0; m_rv = 1;
                end else begin
                    m_el++;
                    if (m_el == MAXMS * TD) begin
                        m_res = MAXMS;
                        m_phase = 0; m_busy = 0; m_led = 0; m_to = 1; m_rv = 1;
                    end
                end
            endcase
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
            #1;
            chk("led", led, m_led);
            chk("busy", busy, m_busy);
            chk("result_ms", result_ms, m_res);
            chk("result_valid", result_valid, m_rv);
            chk("false_start", false_start, m_fs);
            chk("timeout", timeout, m_to);
            chk("rv_not_twice", int'(result_valid && prev_rv), 0);
            prev_rv = result_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_round(output int t0);
        start = 1'b1;
        @(negedge clk);
        t0 = cyc;
        start = 1'b0;
    endtask

    task automatic wait_led(input int maxc, output int rise);
        rise = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (led) begin
                rise = cyc;
                break;
            end
        end
        if (rise < 0) begin
            checks++;
            errors++;
            $display("FAIL wait_led: led never rose within %0d cycles, expected a rise", maxc);
        end
    endtask

    task automatic press_and_release();
        button = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int t0, rise, e;
        logic seen;
        run(2);
        chk("rst_led", led, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result_ms", result_ms, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_flags", {false_start, timeout}, 0);
        reset_n = 1'b1;
        run(3);

        // Normal round: D=3, press 72 cycles after led.
        rnd_ready = 1'b1; random = 14'd3;
        start_round(t0);
        wait_led(100, rise);
        chk("t2_led_latency", rise - (t0 + 1), 30);
        run(71);
        press_and_release();
        chk("t2_valid", result_valid, 1);
        chk("t2_result", result_ms, 7);
        chk("t2_led_off", led, 0);
        chk("t2_busy_off", busy, 0);
        button = 1'b0;
        run(3);

        // False start 12 cycles into a 5 ms delay.
        random = 14'd5;
        start_round(t0);
        run(12);
        press_and_release();
        chk("t3_false_start", false_start, 1);
        chk("t3_valid", result_valid, 1);
        chk("t3_result", result_ms, 0);
        button = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (led) seen = 1'b1;
        end
        chk("t3_led_never", seen, 0);
        chk("t3_idle", busy, 0);

        // Timeout with D=1 and no press.
        random = 14'd1;
        start_round(t0);
        chk("t4_fs_cleared", false_start, 0);
        wait_led(30, rise);
        run(499);
        chk("t4_still_react", led, 1);
        @(negedge clk);
        chk("t4_valid", result_valid, 1);
        chk("t4_result", result_ms, 50);
        chk("t4_timeout", timeout, 1);
        chk("t4_led_off", led, 0);
        run(3);

        // Random source not ready for 100 cycles.
        rnd_ready = 1'b0; random = 14'd2;
        start_round(t0);
        chk("t5_to_cleared", timeout, 0);
        run(100);
        chk("t5_busy", busy, 1);
        chk("t5_led", led, 0);
        rnd_ready = 1'b1;
        e = cyc + 1;
        wait_led(100, rise);
        chk("t5_led_latency", rise - e, 20);
        run(4);
        press_and_release();
        chk("t5_result", result_ms, 0);
        button = 1'b0;
        run(3);

        // Zero delay acts as 1 ms; start in DELAY ignored; press on a tick edge.
        random = 14'd0;
        start_round(t0);
        run(3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_led(40, rise);
        chk("t6_led_latency", rise - (t0 + 1), 10);
        run(69);
        press_and_release();
        chk("t6_result_on_tick", result_ms, 6);
        button = 1'b0;
        run(3);

        // Reset in the middle of REACT.
        start_round(t0);
        wait_led(40, rise);
        run(5);
        reset_n = 1'b0;
        #1;
        chk("t1_led", led, 0);
        chk("t1_busy", busy, 0);
        chk("t1_result_ms", result_ms, 0);
        chk("t1_flags", {false_start, timeout, result_valid}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        run(2);

        // Round after reset.
        start_round(t0);
        wait_led(40, rise);
        chk("t7_led_latency", rise - (t0 + 1), 10);
        run(24);
        press_and_release();
        chk("t7_result", result_ms, 2);
        button = 1'b0;
        run(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
